// File: rtl/jam_pkg.sv
// Shared types and helpers for the exhaustive job-assignment solver.
package jam_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StEval,
    StCmp,
    StDone
  } state_e;

  localparam int unsigned MatchW = 16;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  // Packed identity permutation: slot w holds w.
  function automatic logic [63:0] identity_perm(input int unsigned n, input int unsigned idx_w);
    logic [63:0] r;
    r = '0;
    for (int unsigned w = 0; w < n; w++) r = r | (64'(w) << (w * idx_w));
    return r;
  endfunction

endpackage

// File: rtl/jam_next_perm.sv
// Combinational lexicographic successor of a packed permutation.
module jam_next_perm
  import jam_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic [N*IDX_W-1:0] perm,
  output logic [N*IDX_W-1:0] succ,
  output logic               is_last
);

  logic [IDX_W-1:0] p [N];
  logic [IDX_W-1:0] s [N];
  logic [IDX_W-1:0] q [N];
  int unsigned      piv_i;
  int unsigned      piv_j;

  always_comb begin
    for (int unsigned w = 0; w < N; w++) p[w] = perm[w*IDX_W +: IDX_W];
  end

  always_comb begin
    is_last = 1'b1;
    piv_i   = 0;
    piv_j   = 0;
    // Last ascent wins, giving the largest i with p[i] < p[i+1].
    for (int unsigned i = 0; i < N - 1; i++) begin
      if (p[i] < p[i+1]) begin
        is_last = 1'b0;
        piv_i   = i;
      end
    end
    for (int unsigned j = 0; j < N; j++) begin
      if (j > piv_i && p[j] > p[piv_i]) piv_j = j;
    end
    s        = p;
    s[piv_i] = p[piv_j];
    s[piv_j] = p[piv_i];
    q        = s;
    for (int unsigned k = 0; k < N; k++) begin
      if (k > piv_i) q[k] = s[N + piv_i - k];
    end
    succ = '0;
    for (int unsigned w = 0; w < N; w++) succ[w*IDX_W +: IDX_W] = q[w];
  end

endmodule

// File: rtl/jam_param.sv
// Exhaustive N-worker/N-job assignment solver walking all N! permutations in
// lexicographic order, with optional partial-sum pruning.
module jam_param
  import jam_pkg::*;
#(
  parameter int unsigned N      = 8,
  parameter int unsigned COST_W = 7,
  localparam int unsigned IDX_W = clog2(N),
  localparam int unsigned SUM_W = COST_W + clog2(N)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                START,
  input  logic                PRUNE,
  output logic [IDX_W-1:0]    W,
  output logic [IDX_W-1:0]    J,
  input  logic [COST_W-1:0]   Cost,
  output logic                Busy,
  output logic                Valid,
  output logic [SUM_W-1:0]    MinCost,
  output logic [MatchW-1:0]   MatchCount,
  output logic [N*IDX_W-1:0]  BestPerm
);

  localparam logic [N*IDX_W-1:0] Ident = (N*IDX_W)'(identity_perm(N, IDX_W));

  state_e               state_q, state_d;
  logic [N*IDX_W-1:0]   perm_q, perm_d;
  logic [N*IDX_W-1:0]   best_q, best_d;
  logic [SUM_W-1:0]     acc_q, acc_d;
  logic [SUM_W-1:0]     min_q, min_d;
  logic [MatchW-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]     k_q, k_d;
  logic                 abort_q, abort_d;
  logic                 prune_q, prune_d;

  logic [N*IDX_W-1:0]   succ;
  logic                 is_last;
  logic [SUM_W-1:0]     sum_next;

  jam_next_perm #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_next_perm (
    .perm    (perm_q),
    .succ    (succ),
    .is_last (is_last)
  );

  assign sum_next = acc_q + SUM_W'(Cost);

  always_comb begin
    state_d = state_q;
    perm_d  = perm_q;
    best_d  = best_q;
    acc_d   = acc_q;
    min_d   = min_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    abort_d = abort_q;
    prune_d = prune_q;
    W       = '0;
    J       = '0;
    Busy    = (state_q != StIdle);
    Valid   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (START) begin
          state_d = StEval;
          perm_d  = Ident;
          best_d  = Ident;
          acc_d   = '0;
          min_d   = '1;
          cnt_d   = '0;
          k_d     = '0;
          abort_d = 1'b0;
          prune_d = PRUNE;
        end
      end
      StEval: begin
        W     = k_q;
        J     = perm_q[k_q*IDX_W +: IDX_W];
        acc_d = sum_next;
        k_d   = k_q + 1'b1;
        // Partial sums only grow, so exceeding the best so far is final.
        if (prune_q && (sum_next > min_q)) begin
          abort_d = 1'b1;
          state_d = StCmp;
        end else if (k_q == IDX_W'(N - 1)) begin
          state_d = StCmp;
        end
      end
      StCmp: begin
        if (!abort_q) begin
          if (acc_q < min_q) begin
            min_d  = acc_q;
            cnt_d  = MatchW'(1);
            best_d = perm_q;
          end else if ((acc_q == min_q) && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        if (is_last) begin
          state_d = StDone;
        end else begin
          perm_d  = succ;
          acc_d   = '0;
          k_d     = '0;
          abort_d = 1'b0;
          state_d = StEval;
        end
      end
      StDone: begin
        Valid   = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      perm_q  <= Ident;
      best_q  <= Ident;
      acc_q   <= '0;
      min_q   <= '1;
      cnt_q   <= '0;
      k_q     <= '0;
      abort_q <= 1'b0;
      prune_q <= 1'b0;
    end else begin
      state_q <= state_d;
      perm_q  <= perm_d;
      best_q  <= best_d;
      acc_q   <= acc_d;
      min_q   <= min_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      abort_q <= abort_d;
      prune_q <= prune_d;
    end
  end

  assign MinCost    = min_q;
  assign MatchCount = cnt_q;
  assign BestPerm   = best_q;

endmodule

// File: tb/tb_jam_param.sv
// Bench for jam_param: brute-force reference model over N=3 and N=4 instances.
module tb_jam_param;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic [6:0] cm [8][8];

  logic        start3, prune3, busy3, valid3;
  logic [1:0]  w3, j3;
  logic [6:0]  c3;
  logic [8:0]  min3;
  logic [15:0] mc3;
  logic [5:0]  bp3;

  logic        start4, prune4, busy4, valid4;
  logic [1:0]  w4, j4;
  logic [6:0]  c4;
  logic [8:0]  min4;
  logic [15:0] mc4;
  logic [7:0]  bp4;

  assign c3 = cm[w3][j3];
  assign c4 = cm[w4][j4];

  jam_param #(.N(3), .COST_W(7)) u_dut3 (
    .CLK(CLK), .RST(RST), .START(start3), .PRUNE(prune3), .W(w3), .J(j3), .Cost(c3),
    .Busy(busy3), .Valid(valid3), .MinCost(min3), .MatchCount(mc3), .BestPerm(bp3)
  );

  jam_param #(.N(4), .COST_W(7)) u_dut4 (
    .CLK(CLK), .RST(RST), .START(start4), .PRUNE(prune4), .W(w4), .J(j4), .Cost(c4),
    .Busy(busy4), .Valid(valid4), .MinCost(min4), .MatchCount(mc4), .BestPerm(bp4)
  );

  int n_pass = 0;
  int n_total = 0;

  // Expected results of the run in flight, and the values idle outputs must hold.
  int e3_min, e3_cnt, e3_lat, e4_min, e4_cnt, e4_lat;
  logic [15:0] e3_best, e4_best;
  int h3_min, h3_cnt, h4_min, h4_cnt;
  logic [15:0] h3_best, h4_best;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Enumerate every N-digit base-N tuple in increasing order; the distinct ones are the
  // permutations in lexicographic order. Latency counts samples per permutation plus one.
  task automatic model(input int n, input bit prune, output int mn, output int cnt,
                       output int lat, output logic [15:0] best);
    int d[8];
    int total, r, s, smp;
    bit ok, ab;
    total = 1;
    for (int i = 0; i < n; i++) total *= n;
    mn = 511; cnt = 0; lat = 0; best = '0;
    for (int w = 0; w < n; w++) best[w*2 +: 2] = 2'(w);
    for (int t = 0; t < total; t++) begin
      r = t;
      for (int w = n - 1; w >= 0; w--) begin d[w] = r % n; r = r / n; end
      ok = 1;
      for (int i = 0; i < n; i++)
        for (int j = i + 1; j < n; j++) if (d[i] == d[j]) ok = 0;
      if (!ok) continue;
      s = 0; smp = 0; ab = 0;
      for (int w = 0; w < n && !ab; w++) begin
        s += int'(cm[w][d[w]]);
        smp++;
        if (prune && s > mn) ab = 1;
      end
      lat += smp + 1;
      if (!ab) begin
        if (s < mn) begin
          mn = s; cnt = 1;
          for (int w = 0; w < n; w++) best[w*2 +: 2] = 2'(d[w]);
        end else if (s == mn && cnt < 65535) begin
          cnt++;
        end
      end
    end
  endtask

  always @(negedge CLK) begin
    if (RST) begin
      h3_min = 511; h3_cnt = 0; h3_best = 16'h0024;
      h4_min = 511; h4_cnt = 0; h4_best = 16'h00e4;
    end
    if (valid3) begin
      check("min3", min3, e3_min);
      check("count3", mc3, e3_cnt);
      check("best3", bp3, e3_best[5:0]);
      check("busy3_at_valid", busy3, 1);
      h3_min = e3_min; h3_cnt = e3_cnt; h3_best = e3_best;
    end else if (!busy3) begin
      check("idle3", {w3, j3, min3, mc3, bp3}, {4'b0, 9'(h3_min), 16'(h3_cnt), h3_best[5:0]});
    end
    if (valid4) begin
      check("min4", min4, e4_min);
      check("count4", mc4, e4_cnt);
      check("best4", bp4, e4_best[7:0]);
      check("busy4_at_valid", busy4, 1);
      h4_min = e4_min; h4_cnt = e4_cnt; h4_best = e4_best;
    end else if (!busy4) begin
      check("idle4", {w4, j4, min4, mc4, bp4}, {4'b0, 9'(h4_min), 16'(h4_cnt), h4_best[7:0]});
    end
  end

  task automatic set_start(input int n, input bit v, input bit p);
    if (n == 3) begin start3 = v; prune3 = p; end
    else begin start4 = v; prune4 = p; end
  endtask

  task automatic kick(input int n, input bit prune);
    int guard;
    guard = 0;
    @(negedge CLK);
    while (((n == 3) ? busy3 : busy4) && guard < 2000) begin @(negedge CLK); guard++; end
    if (n == 3) model(3, prune, e3_min, e3_cnt, e3_lat, e3_best);
    else model(4, prune, e4_min, e4_cnt, e4_lat, e4_best);
    set_start(n, 1'b1, prune);
    @(posedge CLK);
    #1;
    // PRUNE must have been latched; scramble it for the rest of the run.
    set_start(n, 1'b0, 1'($urandom));
  endtask

  task automatic run(input int n, input bit prune, input bit poke, output int lat);
    kick(n, prune);
    lat = 0;
    while (!((n == 3) ? valid3 : valid4) && lat < 1000) begin
      if (poke) set_start(n, lat == 30, ~prune);
      @(posedge CLK);
      #1;
      lat++;
    end
    set_start(n, 1'b0, 1'b0);
    check("latency", lat, (n == 3) ? e3_lat : e4_lat);
  endtask

  initial begin
    int lat, lat0;
    RST = 1'b1;
    start3 = 0; prune3 = 0; start4 = 0; prune4 = 0;
    for (int w = 0; w < 8; w++) for (int j = 0; j < 8; j++) cm[w][j] = '0;
    repeat (3) @(negedge CLK);
    check("rst_busy_valid", {busy3, valid3, busy4, valid4}, 0);
    check("rst_min4", min4, 511);
    check("rst_count4", mc4, 0);
    check("rst_best3", bp3, 6'h24);
    check("rst_best4", bp4, 8'he4);
    RST = 1'b0;

    for (int w = 0; w < 3; w++) for (int j = 0; j < 3; j++) cm[w][j] = 7'd5;
    run(3, 0, 0, lat);
    check("pin_min_flat", e3_min, 15);
    check("pin_count_flat", e3_cnt, 6);
    check("pin_best_flat", e3_best, 16'h0024);
    check("pin_lat_flat", lat, 24);

    for (int w = 0; w < 3; w++) for (int j = 0; j < 3; j++) cm[w][j] = (w == j) ? 7'd1 : 7'd10;
    run(3, 0, 0, lat0);
    check("pin_min_diag", e3_min, 3);
    check("pin_count_diag", e3_cnt, 1);
    check("pin_best_diag", e3_best, 16'h0024);
    run(3, 1, 0, lat);
    check("prune_earlier", (lat < lat0) ? 1 : 0, 1);

    for (int w = 0; w < 3; w++)
      for (int j = 0; j < 3; j++) cm[w][j] = (j == 2 - w) ? 7'd0 : 7'd7;
    run(3, 0, 0, lat);
    check("pin_min_anti", e3_min, 0);
    check("pin_count_anti", e3_cnt, 1);
    check("pin_best_anti", e3_best, 16'h0006);
    run(3, 1, 0, lat);
    check("prune_not_later", (lat <= 24) ? 1 : 0, 1);

    for (int w = 0; w < 4; w++) for (int j = 0; j < 4; j++) cm[w][j] = '0;
    run(4, 0, 0, lat);
    check("pin_count_zero4", e4_cnt, 24);
    check("pin_lat4", lat, 120);
    run(4, 1, 0, lat);

    for (int r = 0; r < 12; r++) begin
      for (int w = 0; w < 4; w++)
        for (int j = 0; j < 4; j++)
          cm[w][j] = (r % 3 == 0) ? 7'($urandom_range(0, 3)) : 7'($urandom_range(1, 127));
      run(4, 1'($urandom), r == 4, lat);
    end

    for (int w = 0; w < 4; w++) for (int j = 0; j < 4; j++) cm[w][j] = 7'($urandom_range(0, 127));
    kick(4, 0);
    repeat (50) @(posedge CLK);
    #1 RST = 1'b1;
    #1;
    check("midrst_busy_valid", {busy4, valid4}, 0);
    check("midrst_wj", {w4, j4}, 0);
    check("midrst_min", min4, 511);
    check("midrst_count", mc4, 0);
    check("midrst_best", bp4, 8'he4);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    run(4, 0, 0, lat);
    check("lat_after_reset", lat, 120);

    for (int r = 0; r < 4; r++) begin
      for (int w = 0; w < 3; w++) for (int j = 0; j < 3; j++) cm[w][j] = 7'($urandom_range(0, 15));
      run(3, 1'($urandom), 0, lat);
    end

    repeat (3) @(negedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
